logistic_multi_iter: RTL and testbench
======================================

Name: logistic_multi_iter

Overview:
Parametrised multi-channel logistic-map engine, y = mu*x*(1-x), and the next generation of the per-column trajectory generators feeding the chaos-map display.
- One shared two-stage datapath is time-multiplexed round-robin over NCH channel states, replacing one combinational multiplier pair per channel.
- Start/busy/done handshake.
- Channel results are read back by index for the display colour logic.

Parameters:
W, 17, state width; x unsigned Q0.W (value x/2^W)
MUW, 18, mu width; mu unsigned Q2.(MUW-2), 4.0 = 2^MUW
NCH, 7, channel count, 1..64
ITW, 9, iteration-count width
CHW, $clog2(NCH) (min 1), channel index width (derived)

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  reset; synchronous, active-high
start  in  1  launch pulse; sampled only in IDLE
mu  in  MUW  map parameter, latched at start
times  in  ITW  iterations per channel, latched at start
seed_base  in  W  channel i seed = (seed_base + i) mod 2^W, latched at start
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, high while in FIN
rd_ch  in  CHW  read index
rd_data  out  W  results[rd_ch], combinational; 0 if rd_ch >= NCH

Behaviour:
- Reset (RST=1 at posedge): state = IDLE, every results[i] = 0, busy = 0, done = 0, channel/iteration counters = 0. Reset mid-run aborts the run, with no done pulse.
- FSM states: IDLE, STA, STB, FIN.
- IDLE:
  - On start=1, latch mu/times.
  - Write results[i] = seed_base+i for all i in the same edge; ch = 0; it = 0.
  - Next state is FIN if times == 0, else STA.
  - start=0: stay in IDLE.
- STA: term_r <= x*(2^W - x), where x = results[ch]; (2^W - x) is W+1 bits, so x = 0 gives term 0. term_r is 2W bits; max is 2^(2W-2). Next state: STB.
- STB:
  - results[ch] <= (mu*term_r) >> (W+MUW-2).
  - Result is always < 2^W, so no saturation is needed.
  - If ch == NCH-1: ch = 0, it = it+1, then go to FIN if it+1 == times, else STA.
  - Otherwise ch = ch+1, then go to STA.
- FIN: done = 1 for exactly this cycle, then IDLE.
- Latency:
  - start sampled at edge k: busy = 1 from cycle k+1.
  - done high in cycle k+1+2*NCH*times.
  - busy falls the cycle after done.
- Channel order is strictly 0..NCH-1 each iteration. Each channel is updated once per iteration, using only its own previous value.
- start while busy (including during FIN) is ignored. mu/times/seed_base changes while busy have no effect.
- rd_data reflects a write the cycle after the STB edge that performs it; reads during a run return in-progress values.
- times width ITW: maximum 2^ITW-1 iterations; the it counter never wraps before the compare.

Optional Feature:
Macro LOGISTIC_FREERUN_EN.
- Defined:
  - FIN returns to STA instead of IDLE (it = 0, ch = 0), continuing from the current results with the latched mu/times.
  - done pulses every 2*NCH*times cycles; busy stays 1.
  - A start=1 sampled during FIN reloads mu/times/seeds exactly as from IDLE. FIN then proceeds to STA, or stays cycling through FIN each cycle if the new times = 0.
  - With times == 0 latched, the FSM stays in FIN, done held high, until start or RST.
  - Only RST returns the block to IDLE.
- Not defined: behaviour exactly as above (single run, back to IDLE).

Test Plan:
1. Defaults; assert RST 2 cycles then release -> busy=0, done=0; rd_data=0 for rd_ch 0..6; rd_ch=7 -> 0.
2. mu=131072 (2.0), seed_base=65536, times=5, start at edge k -> busy from k+1; done only in cycle k+71; ch0=65536 (fixed point); ch1=65535; ch2 = value of iterating 65538 five times, checked against the bit-exact model.
3. mu=196608 (3.0), seed_base=65536, times=1 -> done at k+15; ch0=98304 (0.75).
4. times=0, seed_base=131069 -> done at k+1; ch0..ch2 = 131069, 131070, 131071; ch3=0 (wrap); ch6=3.
5. Start a run with times=5; pulse start again at k+20 with different mu -> ignored, final results match the first run. New run: RST=1 at k+10 -> next cycle busy=0, all results 0, no done pulse ever.
6. LOGISTIC_FREERUN_EN defined, mu=131072, seed_base=65537, times=1 -> done pulses at k+15, k+29, k+43; busy stays 1; ch0 stays 65535 after the first pulse.

Source files
------------

// File: rtl/logistic_multi_iter_if.sv
// logistic_multi_iter_if: control, status and result-readback bundle for logistic_multi_iter
interface logistic_multi_iter_if #(
  parameter int W = 17,
  parameter int MUW = 18,
  parameter int NCH = 7,
  parameter int ITW = 9
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  logic start;
  logic [MUW-1:0] mu;
  logic [ITW-1:0] times;
  logic [W-1:0] seed_base;
  logic busy;
  logic done;
  logic [CHW-1:0] rd_ch;
  logic [W-1:0] rd_data;
  modport master(output start, mu, times, seed_base, rd_ch, input busy, done, rd_data);
  modport slave(input start, mu, times, seed_base, rd_ch, output busy, done, rd_data);
endinterface

// File: rtl/logistic_multi_iter.sv
// logistic_multi_iter: one shared two-stage logistic-map datapath round-robined over NCH channels.
// Define LOGISTIC_FREERUN_EN to keep re-running from FIN instead of returning to IDLE.
module logistic_multi_iter #(
  parameter int W = 17,
  parameter int MUW = 18,
  parameter int NCH = 7,
  parameter int ITW = 9
) (
  input logic CLK,
  input logic RST,
  logistic_multi_iter_if.slave io_bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, STA, STB, FIN} state_t;
  state_t r_st, w_nxt;
  logic w_load;
  logic [W-1:0] r_res [NCH];
  logic [CHW-1:0] r_ch;
  logic [ITW-1:0] r_it, r_times;
  logic [MUW-1:0] r_mu;
  logic [2*W-1:0] r_term;
  logic [W-1:0] w_x, w_y;
  logic [W:0] w_omx;
  logic [MUW+2*W-1:0] w_mt;
  logic w_last, w_itdone, w_rd_ok;
  // (2^W - x) needs W+1 bits so that x = 0 yields a zero term
  assign w_x = r_res[r_ch];
  assign w_omx = {1'b1, {W{1'b0}}} - {1'b0, w_x};
  assign w_mt = (MUW+2*W)'(r_mu) * (MUW+2*W)'(r_term);
  assign w_y = W'(w_mt >> (W+MUW-2));
  assign w_last = r_ch == CHW'(NCH-1);
  assign w_itdone = (r_it + ITW'(1)) == r_times;
  assign w_rd_ok = {1'b0, io_bus.rd_ch} < (CHW+1)'(NCH);
  assign io_bus.rd_data = w_rd_ok ? r_res[io_bus.rd_ch] : '0;
  assign io_bus.busy = r_st != IDLE;
  assign io_bus.done = r_st == FIN;
  always_ff @(posedge CLK)
    if (RST) r_st <= IDLE;
    else r_st <= w_nxt;
  always_comb begin
    w_nxt = r_st;
    w_load = 1'b0;
    case (r_st)
      IDLE: begin
        w_load = io_bus.start;
        w_nxt = !io_bus.start ? IDLE : (io_bus.times == '0 ? FIN : STA);
      end
      STA: w_nxt = STB;
      STB: w_nxt = (w_last && w_itdone) ? FIN : STA;
`ifdef LOGISTIC_FREERUN_EN
      FIN: begin
        w_load = io_bus.start;
        w_nxt = io_bus.start ? (io_bus.times == '0 ? FIN : STA) : (r_times == '0 ? FIN : STA);
      end
`else
      FIN: w_nxt = IDLE;
`endif
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      for (int i = 0; i < NCH; i++) r_res[i] <= '0;
      r_ch <= '0;
      r_it <= '0;
      r_mu <= '0;
      r_times <= '0;
      r_term <= '0;
    end else if (w_load) begin
      for (int i = 0; i < NCH; i++) r_res[i] <= io_bus.seed_base + W'(i);
      r_mu <= io_bus.mu;
      r_times <= io_bus.times;
      r_ch <= '0;
      r_it <= '0;
    end else if (r_st == STA) begin
      r_term <= (2*W)'(w_x) * (2*W)'(w_omx);
    end else if (r_st == STB) begin
      r_res[r_ch] <= w_y;
      r_ch <= w_last ? '0 : r_ch + CHW'(1);
      if (w_last) r_it <= r_it + ITW'(1);
    end else if (r_st == FIN) begin
      r_ch <= '0;
      r_it <= '0;
    end
endmodule

// File: tb/tb_logistic_multi_iter.sv
// tb_logistic_multi_iter: scoreboard bench; stimulus queues expected done events and snapshots,
// a monitor pops them on each done pulse (or snapshot request) and sweeps rd_ch 0..7.
module tb_logistic_multi_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;
  logistic_multi_iter_if bus();
  logistic_multi_iter dut(.CLK(clk), .RST(rst), .io_bus(bus));
  typedef struct packed {
    logic is_done;
    logic [31:0] cyc;
    logic [7:0][16:0] res;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic snap_req = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  initial begin
    exp_t e;
    bus.rd_ch = '0;
    forever begin
      @(negedge clk);
      if (bus.done || snap_req) begin
        if (sb.size() == 0) check("unexpected_done", int'(bus.done), 0);
        else begin
          e = sb.pop_front();
          check("done_flag", int'(bus.done), int'(e.is_done));
          if (e.is_done) check("done_cycle", cyc, int'(e.cyc));
          for (int i = 0; i < 8; i++) begin
            bus.rd_ch = 3'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), int'(bus.rd_data), int'(e.res[i]));
          end
        end
      end
    end
  end
  task automatic push_exp(logic is_done, int c, logic [7:0][16:0] r);
    exp_t e;
    e.is_done = is_done;
    e.cyc = 32'(c);
    e.res = r;
    sb.push_back(e);
  endtask
  task automatic snapshot(logic [7:0][16:0] r);
    @(posedge clk);
    push_exp(1'b0, 0, r);
    snap_req = 1'b1;
    @(posedge clk);
    snap_req = 1'b0;
  endtask
  task automatic launch(int mu, int times, int seed, logic exp_done, logic [7:0][16:0] r, output int k);
    @(negedge clk);
    bus.mu = 18'(mu);
    bus.times = 9'(times);
    bus.seed_base = 17'(seed);
    check("busy_pre", int'(bus.busy), 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    bus.start = 1'b0;
    if (exp_done) push_exp(1'b1, k + 14 * times, r);
    @(negedge clk);
    check("busy_post", int'(bus.busy), 1);
  endtask
  task automatic wait_empty(int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask
  logic [7:0][16:0] r;
  int k;
  initial begin
    bus.start = 1'b0;
    bus.mu = '0;
    bus.times = '0;
    bus.seed_base = '0;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    r = '0;
    snapshot(r);
`ifndef LOGISTIC_FREERUN_EN
    // mu=2.0: 0.5 is a fixed point, neighbours collapse to 65535
    r = '0;
    r[0] = 17'd65536;
    for (int i = 1; i < 7; i++) r[i] = 17'd65535;
    launch(131072, 5, 65536, 1'b1, r, k);
    wait_empty(200);
    @(negedge clk);
    check("busy_fall", int'(bus.busy), 0);
    // mu=3.0 single iteration
    r = '0;
    r[0] = 17'd98304;
    for (int i = 1; i < 7; i++) r[i] = 17'd98303;
    launch(196608, 1, 65536, 1'b1, r, k);
    wait_empty(100);
    @(negedge clk);
    check("busy_fall3", int'(bus.busy), 0);
    // times=0 seeds with wrap
    r = '0;
    r[0] = 17'd131069; r[1] = 17'd131070; r[2] = 17'd131071;
    r[3] = 17'd0; r[4] = 17'd1; r[5] = 17'd2; r[6] = 17'd3;
    launch(131072, 0, 131069, 1'b1, r, k);
    wait_empty(20);
    @(negedge clk);
    check("busy_fall4", int'(bus.busy), 0);
    // start while busy with different mu is ignored
    r = '0;
    r[0] = 17'd65536;
    for (int i = 1; i < 7; i++) r[i] = 17'd65535;
    launch(131072, 5, 65536, 1'b1, r, k);
    while (cyc < k + 19) @(negedge clk);
    bus.mu = 18'd196608;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_empty(200);
    @(negedge clk);
    check("busy_fall5", int'(bus.busy), 0);
    // reset mid-run aborts without done
    launch(131072, 5, 65536, 1'b0, r, k);
    while (cyc < k + 9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    rst = 1'b0;
    r = '0;
    snapshot(r);
    repeat (150) @(posedge clk);
    check("abort_sb_empty", sb.size(), 0);
`else
    // free-running: done every 14 cycles, busy held
    r = '0;
    for (int i = 0; i < 7; i++) r[i] = 17'd65535;
    launch(131072, 1, 65537, 1'b1, r, k);
    push_exp(1'b1, k + 28, r);
    push_exp(1'b1, k + 42, r);
    wait_empty(100);
    @(negedge clk);
    check("fr_busy", int'(bus.busy), 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("fr_rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
`endif
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
